// File: rtl/clkdiv_sched_if.sv
// Ratio-write port for the clock-divider scheduler: valid/ready, channel and new ratio.
interface clkdiv_sched_if #(
  parameter int unsigned DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_chan;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_chan, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_chan, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clkdiv_sched.sv
// Clock-divider scheduler: Schmitt-detects a clock and a reset trigger on the sample
// path and drives four gates, each dividing the clock by its own run-time ratio.
// Ratio writes are held in a shadow register and applied only at the channel's wrap.
module clkdiv_sched #(
  parameter int unsigned        DIV_W      = 8,
  parameter logic signed [15:0] SCHMITT_HI = 16'sd8000,
  parameter logic signed [15:0] SCHMITT_LO = 16'sd2000,
  parameter logic signed [15:0] OUT_HI     = 16'sd20000,
  parameter logic signed [15:0] OUT_LO     = 16'sd0,
  parameter int unsigned        DIV_INIT0  = 1,
  parameter int unsigned        DIV_INIT1  = 2,
  parameter int unsigned        DIV_INIT2  = 4,
  parameter int unsigned        DIV_INIT3  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_strobe,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  clkdiv_sched_if.slave      cfg,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3
);

  localparam int unsigned N_CH = 4;
  localparam logic [DIV_W-1:0] DIV_INIT [N_CH] = '{
    DIV_W'(DIV_INIT0), DIV_W'(DIV_INIT1), DIV_W'(DIV_INIT2), DIV_W'(DIV_INIT3)
  };

  logic             clk_hi;
  logic             rst_hi;
  logic             strobe_d;
  logic [DIV_W-1:0] cnt    [N_CH];
  logic [DIV_W-1:0] div    [N_CH];
  logic [DIV_W-1:0] shadow [N_CH];
  logic [N_CH-1:0]  pending;
  logic             clk_ev;
  logic             rst_ev;
  logic             accept;

  // Rising events from the Schmitt detectors, only on a sample strobe
  always_comb begin
    clk_ev = sample_strobe && (sample_in0 > SCHMITT_HI) && !clk_hi;
    rst_ev = sample_strobe && (sample_in1 > SCHMITT_HI) && !rst_hi;
  end

  // A channel accepts a new ratio only while it has none pending
  assign cfg.cfg_ready = !pending[cfg.cfg_chan];
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  // Gate level for one channel from its ratio, count and the clock state
  function automatic logic signed [15:0] gate(input logic [DIV_W-1:0] d,
                                              input logic [DIV_W-1:0] c,
                                              input logic             hi);
    if (d == '0)               return OUT_LO;
    else if (d == DIV_W'(1))   return hi ? OUT_HI : OUT_LO;
    else                       return (c < (d >> 1)) ? OUT_HI : OUT_LO;
  endfunction

  // Schmitt state for the clock and reset-trigger inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_hi <= 1'b0;
      rst_hi <= 1'b0;
    end else if (sample_strobe) begin
      if ((sample_in0 > SCHMITT_HI) && !clk_hi)     clk_hi <= 1'b1;
      else if ((sample_in0 < SCHMITT_LO) && clk_hi) clk_hi <= 1'b0;
      if ((sample_in1 > SCHMITT_HI) && !rst_hi)     rst_hi <= 1'b1;
      else if ((sample_in1 < SCHMITT_LO) && rst_hi) rst_hi <= 1'b0;
    end
  end

  // Per-channel counters, ratio shadow registers and deferred ratio application
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int n = 0; n < N_CH; n++) begin
        cnt[n]    <= '0;
        div[n]    <= DIV_INIT[n];
        shadow[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_CH; n++) begin
        if (rst_ev) begin
          cnt[n] <= '0;
          if (pending[n]) begin
            div[n]     <= shadow[n];
            pending[n] <= 1'b0;
          end
        end else if (clk_ev && (div[n] >= DIV_W'(2))) begin
          if (cnt[n] == div[n] - DIV_W'(1)) begin
            cnt[n] <= '0;
            if (pending[n]) begin
              div[n]     <= shadow[n];
              pending[n] <= 1'b0;
            end
          end else begin
            cnt[n] <= cnt[n] + DIV_W'(1);
          end
        end else if (pending[n] && (clk_ev || (div[n] == '0))) begin
          // Ratio 0/1 has no period to finish; a muted channel does not even wait for a clock
          cnt[n]     <= '0;
          div[n]     <= shadow[n];
          pending[n] <= 1'b0;
        end
        if (accept && (cfg.cfg_chan == 2'(n))) begin
          shadow[n]  <= cfg.cfg_div;
          pending[n] <= 1'b1;
        end
      end
    end
  end

  // Gate outputs refresh one clock after each strobe and hold in between
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_d    <= 1'b0;
      sample_out0 <= OUT_LO;
      sample_out1 <= OUT_LO;
      sample_out2 <= OUT_LO;
      sample_out3 <= OUT_LO;
    end else begin
      strobe_d <= sample_strobe;
      if (strobe_d) begin
        sample_out0 <= gate(div[0], cnt[0], clk_hi);
        sample_out1 <= gate(div[1], cnt[1], clk_hi);
        sample_out2 <= gate(div[2], cnt[2], clk_hi);
        sample_out3 <= gate(div[3], cnt[3], clk_hi);
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Self-checking bench for clkdiv_sched: a behavioural model predicts the gates for each
// strobe; predictions are queued at the strobe and compared when the outputs refresh.
module tb_clkdiv_sched;

  localparam int unsigned DIV_W = 8;
  localparam int HI = 20000;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_strobe;
  logic signed [15:0] sample_in0;
  logic signed [15:0] sample_in1;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;
  logic signed [15:0] sample_out2;
  logic signed [15:0] sample_out3;

  clkdiv_sched_if #(.DIV_W(DIV_W)) cfg_bus ();

  clkdiv_sched #(.DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_strobe (sample_strobe),
    .sample_in0    (sample_in0),
    .sample_in1    (sample_in1),
    .cfg           (cfg_bus),
    .sample_out0   (sample_out0),
    .sample_out1   (sample_out1),
    .sample_out2   (sample_out2),
    .sample_out3   (sample_out3)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q [$];

  bit m_clk_hi, m_rst_hi;
  int m_cnt [4];
  int m_div [4];
  int m_sh  [4];
  bit m_pend [4];
  int ev_cnt;
  int prev_out0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int gate_exp(input int n);
    if (m_div[n] == 0)      return 0;
    else if (m_div[n] == 1) return m_clk_hi ? HI : 0;
    else                    return (m_cnt[n] < m_div[n] / 2) ? HI : 0;
  endfunction

  function automatic logic [63:0] model_outs();
    return {16'(gate_exp(3)), 16'(gate_exp(2)), 16'(gate_exp(1)), 16'(gate_exp(0))};
  endfunction

  task automatic m_reset();
    m_clk_hi = 0;
    m_rst_hi = 0;
    m_div    = '{1, 2, 4, 8};
    for (int n = 0; n < 4; n++) begin
      m_cnt[n]  = 0;
      m_sh[n]   = 0;
      m_pend[n] = 0;
    end
  endtask

  task automatic m_apply(input int n);
    m_div[n]  = m_sh[n];
    m_cnt[n]  = 0;
    m_pend[n] = 0;
  endtask

  task automatic m_step(input int in0, input int in1);
    bit ce, re;
    ce = (in0 > 8000) && !m_clk_hi;
    re = (in1 > 8000) && !m_rst_hi;
    if (ce) m_clk_hi = 1; else if (in0 < 2000 && m_clk_hi) m_clk_hi = 0;
    if (re) m_rst_hi = 1; else if (in1 < 2000 && m_rst_hi) m_rst_hi = 0;
    for (int n = 0; n < 4; n++) begin
      if (re) begin
        m_cnt[n] = 0;
        if (m_pend[n]) m_apply(n);
      end else if (ce) begin
        if (m_div[n] >= 2) begin
          if (m_cnt[n] == m_div[n] - 1) begin
            m_cnt[n] = 0;
            if (m_pend[n]) m_apply(n);
          end else begin
            m_cnt[n]++;
          end
        end else if (m_pend[n]) begin
          m_apply(n);
        end
      end
    end
  endtask

  function automatic logic [63:0] dut_outs();
    return {sample_out3, sample_out2, sample_out1, sample_out0};
  endfunction

  // One strobe: predict, queue, then compare once the outputs have refreshed
  task automatic strobe(input int a, input int b, input string tag);
    @(negedge clk);
    sample_in0    = 16'(a);
    sample_in1    = 16'(b);
    sample_strobe = 1'b1;
    m_step(a, b);
    exp_q.push_back(model_outs());
    @(negedge clk);
    sample_strobe = 1'b0;
    @(negedge clk);
    check(tag, dut_outs(), exp_q.pop_front());
    if (int'(sample_out0) == HI && prev_out0 != HI) ev_cnt++;
    prev_out0 = int'(sample_out0);
  endtask

  task automatic pulse(input string tag);
    strobe(12000, 0, tag);
    strobe(0, 0, tag);
  endtask

  task automatic check_ready(input int n, input string tag);
    cfg_bus.cfg_chan = 2'(n);
    #1;
    check(tag, 64'(cfg_bus.cfg_ready), 64'(!m_pend[n]));
  endtask

  task automatic cfg_write(input int n, input int d);
    bit acc;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_chan  = 2'(n);
    cfg_bus.cfg_div   = DIV_W'(d);
    #1;
    acc = !m_pend[n];
    check("cfg_ready_at_write", 64'(cfg_bus.cfg_ready), 64'(acc));
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    if (acc) begin
      m_sh[n]   = d;
      m_pend[n] = 1;
    end
    @(negedge clk);
    if (m_pend[n] && m_div[n] == 0) m_apply(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    prev_out0 = 0;
  endtask

  initial begin
    logic [63:0] held;
    rst               = 1'b1;
    sample_strobe     = 1'b0;
    sample_in0        = '0;
    sample_in1        = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_chan  = '0;
    cfg_bus.cfg_div   = '0;
    ev_cnt            = 0;

    // Reset defaults
    do_reset();
    check("reset_outs", dut_outs(), 64'd0);
    for (int n = 0; n < 4; n++) check_ready(n, "reset_ready");
    for (int i = 0; i < 16; i++) pulse("defaults");

    // Hysteresis, including strict thresholds and a negative excursion
    ev_cnt = 0;
    strobe(0, 0, "hyst");
    strobe(7999, 0, "hyst");
    strobe(1000, 0, "hyst");
    strobe(8001, 0, "hyst");
    check("hyst_seq1_events", 64'(ev_cnt), 64'd1);
    strobe(2500, 0, "hyst");
    strobe(8001, 0, "hyst");
    check("hyst_seq2_events", 64'(ev_cnt), 64'd1);
    strobe(-5000, 0, "hyst");
    strobe(8000, 0, "hyst");
    check("hyst_at_threshold", 64'(ev_cnt), 64'd1);
    strobe(0, 0, "hyst");

    // Glitch-free retune of ch3 from /8 to /4 at cnt=2
    strobe(0, 12000, "retune_rst");
    strobe(0, 0, "retune_rst");
    pulse("retune");
    pulse("retune");
    cfg_write(3, 4);
    check("retune_ready_low", 64'(cfg_bus.cfg_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pulse("retune_old");
      check_ready(3, "retune_ready");
    end
    check("retune_ready_before_wrap", 64'(cfg_bus.cfg_ready), 64'd0);
    pulse("retune_wrap");
    check_ready(3, "retune_ready");
    check("retune_ready_after_wrap", 64'(cfg_bus.cfg_ready), 64'd1);
    for (int i = 0; i < 5; i++) pulse("retune_new");

    // Reset trigger and clock on the same strobe
    strobe(12000, 12000, "rst_wins");
    check("rst_wins_out2_cnt0", 64'(sample_out2), 64'(HI));
    strobe(0, 0, "rst_wins");
    strobe(12000, 0, "rst_wins_next");
    check("rst_wins_out1_cnt1", 64'(sample_out1), 64'd0);
    strobe(0, 0, "rst_wins_next");

    // Mute ch2, then unmute at /3; ch1 write alongside is independent
    cfg_write(2, 0);
    cfg_write(1, 3);
    for (int i = 0; i < 5; i++) pulse("mute");
    check("muted_out2", 64'(sample_out2), 64'd0);
    cfg_write(2, 3);
    check_ready(2, "unmute_ready");
    strobe(0, 0, "unmute_idle");
    check("unmute_out2_high", 64'(sample_out2), 64'(HI));
    for (int i = 0; i < 6; i++) pulse("unmute");

    // No change without a strobe
    held = model_outs();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_in0 = (i % 2 == 0) ? 16'sd12000 : 16'sd0;
      sample_in1 = (i % 2 == 0) ? 16'sd12000 : 16'sd0;
    end
    @(negedge clk);
    check("no_strobe_hold", dut_outs(), held);
    sample_in0 = '0;
    sample_in1 = '0;
    strobe(0, 0, "no_strobe_after");
    pulse("no_strobe_after");

    // Reset mid-operation drops a pending write
    cfg_write(3, 5);
    check_ready(3, "pending_before_rst");
    do_reset();
    check("midrst_outs", dut_outs(), 64'd0);
    check_ready(3, "midrst_ready");
    for (int i = 0; i < 8; i++) pulse("midrst_defaults");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
